// File: rtl/alu_core_if.sv
// Execute-stage ALU bus: operand/control issue side and registered result side.
// The issuing stage uses the master modport, the ALU uses the slave modport.
interface alu_core_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             out_valid;

  modport master (
    output in_valid, op_a, op_b, alu_ctrl,
    input  result, zero, overflow, out_valid
  );

  modport slave (
    input  in_valid, op_a, op_b, alu_ctrl,
    output result, zero, overflow, out_valid
  );
endinterface

// File: rtl/alu_core.sv
// 32-bit integer ALU for the execute stage: nine operations selected by alu_ctrl.
// Result, zero and overflow are registered with one cycle of latency.
module alu_core #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  alu_core_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SLT = 4'b0101,
    OP_SLL = 4'b0110,
    OP_SRL = 4'b0111,
    OP_SRA = 4'b1000
  } alu_op_e;

  // Signed overflow on a + b: same-sign operands producing an opposite-sign sum.
  function automatic logic add_ovf(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Signed overflow on a - b: differing-sign operands where the difference loses a's sign.
  function automatic logic sub_ovf(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] d);
    return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
  endfunction

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [SHW-1:0]   shamt_s;
  logic             lt_s;
  logic [WIDTH-1:0] next_result_s;
  logic             next_ovf_s;
  logic             next_zero_s;

  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             overflow_r;
  logic             out_valid_r;

  // Shared adder/subtractor and shift amount feeding the operation mux.
  always_comb begin
    sum_s   = bus.op_a + bus.op_b;
    diff_s  = bus.op_a - bus.op_b;
    shamt_s = bus.op_b[SHW-1:0];
    // Differing signs decide directly; otherwise the difference cannot overflow.
    if (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) begin
      lt_s = bus.op_a[WIDTH-1];
    end else begin
      lt_s = diff_s[WIDTH-1];
    end
  end

  // Operation select producing the next result and overflow flag.
  always_comb begin
    next_result_s = {WIDTH{1'b0}};
    next_ovf_s    = 1'b0;
    case (bus.alu_ctrl)
      OP_ADD: begin
        next_result_s = sum_s;
        next_ovf_s    = add_ovf(bus.op_a, bus.op_b, sum_s);
      end
      OP_SUB: begin
        next_result_s = diff_s;
        next_ovf_s    = sub_ovf(bus.op_a, bus.op_b, diff_s);
      end
      OP_AND: next_result_s = bus.op_a & bus.op_b;
      OP_OR:  next_result_s = bus.op_a | bus.op_b;
      OP_XOR: next_result_s = bus.op_a ^ bus.op_b;
      OP_SLT: next_result_s = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLL: next_result_s = bus.op_a << shamt_s;
      OP_SRL: next_result_s = bus.op_a >> shamt_s;
      OP_SRA: next_result_s = $unsigned($signed(bus.op_a) >>> shamt_s);
      default: begin
        next_result_s = {WIDTH{1'b0}};
        next_ovf_s    = 1'b0;
      end
    endcase
    next_zero_s = (next_result_s == {WIDTH{1'b0}});
  end

  // Output registers: reset wins, accepted ops load, idle cycles hold the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b1;
      overflow_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (bus.in_valid) begin
      result_r    <= next_result_s;
      zero_r      <= next_zero_s;
      overflow_r  <= next_ovf_s;
      out_valid_r <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.result    = result_r;
  assign bus.zero      = zero_r;
  assign bus.overflow  = overflow_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: hand-computed results, flags and valid timing.
`timescale 1ns/1ps
module tb_alu_core;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;

  alu_core_if #(.WIDTH(32)) bus ();

  alu_core #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_cnt++;
    if (observed !== expected) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one operation, advance one edge, and check all outputs just after it.
  task automatic apply_op(input string tag, input logic [3:0] ctrl,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_zero,
                          input logic exp_ovf);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = ctrl;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk);
    #1;
    check_value({tag, ".result"},   bus.result,             exp_res);
    check_value({tag, ".zero"},     32'(bus.zero),          32'(exp_zero));
    check_value({tag, ".overflow"}, 32'(bus.overflow),      32'(exp_ovf));
    check_value({tag, ".valid"},    32'(bus.out_valid),     32'd1);
  endtask

  task automatic check_outs(input string tag, input logic [31:0] exp_res,
                            input logic exp_zero, input logic exp_ovf,
                            input logic exp_valid);
    check_value({tag, ".result"},   bus.result,         exp_res);
    check_value({tag, ".zero"},     32'(bus.zero),      32'(exp_zero));
    check_value({tag, ".overflow"}, 32'(bus.overflow),  32'(exp_ovf));
    check_value({tag, ".valid"},    32'(bus.out_valid), 32'(exp_valid));
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;

    // Reset held for two edges with a live, overflowing ADD on the inputs.
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 4'b0000;
    bus.op_a     = 32'h7FFF_FFFF;
    bus.op_b     = 32'h0000_0001;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outs("reset", 32'h0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    apply_op("add_small", 4'b0000, 32'h5,         32'h3,         32'h8,         1'b0, 1'b0);
    apply_op("add_ovf",   4'b0000, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1);
    apply_op("add_zero",  4'b0000, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0);
    apply_op("add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0);
    apply_op("add_negov", 4'b0000, 32'h8000_0000, 32'h8000_0000, 32'h0,         1'b1, 1'b1);
    apply_op("sub_small", 4'b0001, 32'h5,         32'h3,         32'h2,         1'b0, 1'b0);
    apply_op("sub_ovf",   4'b0001, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b1);
    apply_op("sub_eq",    4'b0001, 32'h1234_5678, 32'h1234_5678, 32'h0,         1'b1, 1'b0);
    apply_op("sub_posov", 4'b0001, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
    apply_op("slt_neg",   4'b0101, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0);
    apply_op("slt_pos",   4'b0101, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0);
    apply_op("slt_ovf",   4'b0101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0);
    apply_op("slt_rev",   4'b0101, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0,         1'b1, 1'b0);
    apply_op("and",       4'b0010, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0);
    apply_op("or",        4'b0011, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F, 1'b0, 1'b0);
    apply_op("xor",       4'b0100, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0, 1'b0);
    apply_op("sll",       4'b0110, 32'h1,         32'h4,         32'h10,        1'b0, 1'b0);
    apply_op("sll_31",    4'b0110, 32'h3,         32'h1F,        32'h8000_0000, 1'b0, 1'b0);
    apply_op("srl",       4'b0111, 32'h8000_0000, 32'h4,         32'h0800_0000, 1'b0, 1'b0);
    apply_op("sra",       4'b1000, 32'h8000_0000, 32'h4,         32'hF800_0000, 1'b0, 1'b0);
    apply_op("sra_mask",  4'b1000, 32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0, 1'b0);
    apply_op("sra_pos",   4'b1000, 32'h4000_0000, 32'h1E,        32'h1,         1'b0, 1'b0);
    apply_op("srl_0",     4'b0111, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    apply_op("sll_0",     4'b0110, 32'hCAFE_F00D, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0);
    apply_op("undef_f",   4'b1111, 32'h7FFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0);
    apply_op("undef_9",   4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0);

    // Three back-to-back ops, then idle cycles with changing inputs must hold outputs.
    apply_op("b2b_0", 4'b0000, 32'h10, 32'h20, 32'h30,     1'b0, 1'b0);
    apply_op("b2b_1", 4'b0011, 32'hA0, 32'h0B, 32'hAB,     1'b0, 1'b0);
    apply_op("b2b_2", 4'b0111, 32'hF0, 32'h4,  32'h0F,     1'b0, 1'b0);
    bus.in_valid = 1'b0;
    bus.alu_ctrl = 4'b0001;
    bus.op_a     = 32'h8000_0000;
    bus.op_b     = 32'h1;
    @(posedge clk);
    #1;
    check_outs("idle_0", 32'h0F, 1'b0, 1'b0, 1'b0);
    bus.alu_ctrl = 4'b0000;
    bus.op_a     = 32'h0;
    bus.op_b     = 32'h0;
    @(posedge clk);
    #1;
    check_outs("idle_1", 32'h0F, 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-stream overrides a valid overflowing op.
    apply_op("pre_rst", 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 4'b0000;
    bus.op_a     = 32'h7FFF_FFFF;
    bus.op_b     = 32'h2;
    @(posedge clk);
    #1;
    check_outs("mid_rst", 32'h0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    apply_op("post_rst", 4'b0100, 32'h55, 32'hFF, 32'hAA, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
